// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: periodically issues the host start pulse and decodes
// the 40-bit sensor frame, publishing humidity/temperature when the checksum matches.
module dht11_reader #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_LOW_US  = 18000,
    parameter int PERIOD_US     = 2000000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200
) (
    input  logic        clk50M,
    input  logic        reset,
    inout  wire         io_dht11,
    output logic [31:0] dht11_data,
    output logic        dht11_data_valid,
    output logic        dht11_cksum_err,
    output logic        dht11_timeout_err
);

    localparam int DIV_W  = ($clog2(CLKS_PER_US) > 0) ? $clog2(CLKS_PER_US) : 1;
    localparam int PER_W  = $clog2(PERIOD_US + 1);
    localparam int PH_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, START_LOW, WAIT_ACK_LOW, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div;
    logic [PER_W-1:0]   per_us;
    logic [PH_W-1:0]    ph_us;
    logic               sync1, sync2, prev;
    logic               rel_seen;
    logic [39:0]        shreg;
    logic [5:0]         bit_cnt;
    logic [7:0]         sum;
    logic               tick, per_exp, ph_to, rise, fall;
    logic               clr_frame, shift_en, ck_ok, ck_bad, to_err;

    assign tick     = (div == DIV_W'(CLKS_PER_US - 1));
    assign per_exp  = tick && (per_us == PER_W'(PERIOD_US - 1));
    assign ph_to    = tick && (ph_us == PH_W'(TIMEOUT_US - 1));
    assign rise     = sync2 && !prev;
    assign fall     = !sync2 && prev;
    assign sum      = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
    assign io_dht11 = (state == START_LOW) ? 1'b0 : 1'bz;

    always_comb begin
        state_nx  = state;
        clr_frame = 1'b0;
        shift_en  = 1'b0;
        ck_ok     = 1'b0;
        ck_bad    = 1'b0;
        to_err    = 1'b0;
        case (state)
            IDLE:      if (per_exp) state_nx = START_LOW;
            START_LOW: if (tick && ph_us == PH_W'(START_LOW_US - 1)) state_nx = WAIT_ACK_LOW;
            // The synchronizer still holds our own start pulse for a couple of
            // cycles after release, so only a low seen after a high counts as ack.
            WAIT_ACK_LOW: begin
                if (!sync2 && rel_seen) state_nx = ACK_LOW;
                else if (ph_to) begin state_nx = IDLE; to_err = 1'b1; end
            end
            ACK_LOW: begin
                if (rise) state_nx = ACK_HIGH;
                else if (ph_to) begin state_nx = IDLE; to_err = 1'b1; end
            end
            ACK_HIGH: begin
                if (fall) begin state_nx = BIT_LOW; clr_frame = 1'b1; end
                else if (ph_to) begin state_nx = IDLE; to_err = 1'b1; end
            end
            BIT_LOW: begin
                if (rise) state_nx = BIT_HIGH;
                else if (ph_to) begin state_nx = IDLE; to_err = 1'b1; end
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_en = 1'b1;
                    state_nx = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                end else if (ph_to) begin
                    state_nx = IDLE;
                    to_err   = 1'b1;
                end
            end
            CHECK: begin
                if (shreg[7:0] == sum) ck_ok = 1'b1;
                else ck_bad = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state             <= IDLE;
            div               <= '0;
            per_us            <= '0;
            ph_us             <= '0;
            sync1             <= 1'b1;
            sync2             <= 1'b1;
            prev              <= 1'b1;
            rel_seen          <= 1'b0;
            shreg             <= '0;
            bit_cnt           <= '0;
            dht11_data        <= '0;
            dht11_data_valid  <= 1'b0;
            dht11_cksum_err   <= 1'b0;
            dht11_timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            div      <= tick ? '0 : div + DIV_W'(1);
            sync1    <= io_dht11;
            sync2    <= sync1;
            prev     <= sync2;
            rel_seen <= (state == WAIT_ACK_LOW) && (rel_seen || sync2);
            if (tick) per_us <= per_exp ? '0 : per_us + PER_W'(1);
            // Phase timer restarts on every state change; in BIT_HIGH it is the high time.
            if (state_nx != state || state == IDLE) ph_us <= '0;
            else if (tick) ph_us <= ph_us + PH_W'(1);
            if (clr_frame) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[38:0], (ph_us > PH_W'(BIT_THRESH_US))};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (ck_ok) dht11_data <= shreg[39:8];
            dht11_data_valid  <= ck_ok;
            dht11_cksum_err   <= ck_bad;
            dht11_timeout_err <= to_err;
        end
    end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: a behavioural sensor answers host start pulses
// with hand-built frames; pulses, data and start timing are checked against constants.
`timescale 1ns/1ps
module tb_dht11_reader;

    localparam int CLKS   = 2;
    localparam int SLOW   = 20;
    localparam int PER    = 2000;
    localparam int THR    = 40;
    localparam int TO     = 200;
    localparam int CLK_NS = 10;
    localparam int US     = CLK_NS * CLKS;

    logic        clk50M = 1'b0;
    logic        reset = 1'b1;
    logic        sensor_low = 1'b0;
    wire         bus;
    logic [31:0] data;
    logic        valid, ckerr, toerr;

    assign bus = sensor_low ? 1'b0 : 1'bz;
    pullup (bus);

    dht11_reader #(
        .CLKS_PER_US(CLKS), .START_LOW_US(SLOW), .PERIOD_US(PER),
        .BIT_THRESH_US(THR), .TIMEOUT_US(TO)
    ) dut (
        .clk50M(clk50M), .reset(reset), .io_dht11(bus), .dht11_data(data),
        .dht11_data_valid(valid), .dht11_cksum_err(ckerr), .dht11_timeout_err(toerr)
    );

    always #(CLK_NS/2) clk50M = ~clk50M;

    int  n_chk = 0, n_err = 0;
    int  n_valid = 0, n_ck = 0, n_to = 0, n_multi = 0, n_start = 0;
    logic [31:0] valid_data = '0;
    time t_start = 0, t_rel = 0, t_to = 0;
    bit  host_low = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk50M) begin
        if (valid) begin n_valid <= n_valid + 1; valid_data <= data; end
        if (ckerr) n_ck <= n_ck + 1;
        if (toerr) begin n_to <= n_to + 1; t_to <= $time; end
        if (int'(valid) + int'(ckerr) + int'(toerr) > 1) n_multi <= n_multi + 1;
    end

    // A bus low the sensor did not cause is the host start pulse.
    always @(negedge bus) if (!sensor_low) begin
        n_start  <= n_start + 1;
        t_start  <= $time;
        host_low <= 1'b1;
    end
    always @(posedge bus) if (host_low) begin
        host_low <= 1'b0;
        t_rel    <= $time;
    end

    task automatic wait_start(output bit ok);
        int s0;
        s0 = n_start;
        ok = 1'b0;
        for (int i = 0; i < 3 * PER * CLKS; i++) begin
            @(negedge clk50M);
            if (n_start != s0 && !host_low) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_frame(input logic [39:0] f, input int zero_hi, input int abort_bit);
        bit ok;
        wait_start(ok);
        chk("start_seen", ok, 1);
        #(20*US); sensor_low = 1'b1; #(80*US); sensor_low = 1'b0; #(80*US);
        for (int i = 0; i < 40; i++) begin
            sensor_low = 1'b1; #(50*US); sensor_low = 1'b0;
            if (i == abort_bit) return;
            #((f[39-i] ? 70 : zero_hi) * US);
        end
        sensor_low = 1'b1; #(50*US); sensor_low = 1'b0; #(10*US);
    endtask

    initial begin
        #(700_000);
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time t0, tprev, dt;
        int  v0, c0, e0;
        bit  ok;

        repeat (4) @(posedge clk50M);
        @(negedge clk50M);
        chk("rst_data", data, 32'h0);
        chk("rst_pulses", {valid, ckerr, toerr}, 3'b000);
        chk("rst_bus", bus, 1);
        @(posedge clk50M); t0 = $time;
        @(negedge clk50M); reset = 1'b0;

        // good frame, 27 us zeros / 70 us ones
        v0 = n_valid; c0 = n_ck; e0 = n_to;
        send_frame(40'h37_00_19_00_50, 27, -1);
        chk("f1_first_start", t_start - t0, PER * US);
        chk("f1_start_len", t_rel - t_start, SLOW * US);
        chk("f1_valid", n_valid - v0, 1);
        chk("f1_no_err", (n_ck - c0) + (n_to - e0), 0);
        chk("f1_vdata", valid_data, 32'h37001900);
        chk("f1_data", data, 32'h37001900);

        // bad checksum, data must hold
        v0 = n_valid; c0 = n_ck; e0 = n_to;
        send_frame(40'h37_00_19_00_51, 27, -1);
        chk("f2_ckerr", n_ck - c0, 1);
        chk("f2_no_valid", (n_valid - v0) + (n_to - e0), 0);
        chk("f2_data_hold", data, 32'h37001900);

        // checksum wraps mod 256
        v0 = n_valid; c0 = n_ck;
        send_frame(40'hFF_FF_01_00_FF, 27, -1);
        chk("f3_valid", n_valid - v0, 1);
        chk("f3_no_ckerr", n_ck - c0, 0);
        chk("f3_data", data, 32'hFFFF0100);

        // zeros held high exactly at the threshold still decode as 0
        v0 = n_valid; c0 = n_ck;
        send_frame(40'h37_00_19_00_50, 40, -1);
        chk("f4_valid", n_valid - v0, 1);
        chk("f4_no_ckerr", n_ck - c0, 0);
        chk("f4_data", data, 32'h37001900);

        // sensor silent: timeout after release
        v0 = n_valid; e0 = n_to;
        wait_start(ok);
        chk("f5_start_seen", ok, 1);
        tprev = t_start;
        for (int i = 0; i < (TO + 20) * CLKS; i++) begin
            @(negedge clk50M);
            if (n_to != e0) break;
        end
        chk("f5_timeout", n_to - e0, 1);
        dt = t_to - t_rel;
        chk("f5_to_latency", (dt >= TO * US) && (dt <= TO * US + 3 * CLK_NS), 1);
        chk("f5_data_hold", data, 32'h37001900);
        chk("f5_no_valid", n_valid - v0, 0);

        // reset in the middle of bit 20
        send_frame(40'h37_00_19_00_50, 27, 20);
        chk("f6_period_gap", t_start - tprev, PER * US);
        v0 = n_valid + n_ck + n_to;
        #(10*US);
        @(negedge clk50M); reset = 1'b1;
        @(posedge clk50M); #1;
        chk("f6_bus_released", bus, 1);
        repeat (3) @(negedge clk50M);
        chk("f6_rst_data", data, 32'h0);
        @(posedge clk50M); t0 = $time;
        @(negedge clk50M); reset = 1'b0;
        wait_start(ok);
        chk("f6_restart_seen", ok, 1);
        chk("f6_restart_time", t_start - t0, PER * US);
        chk("f6_no_pulses", n_valid + n_ck + n_to - v0, 0);
        chk("f6_data_zero", data, 32'h0);
        chk("one_hot_pulses", n_multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
